// File: rtl/pipeline_ctrl_pkg.sv
// rv32i_types: shared type definitions for the rv32i pipeline.
// Holds the state encoding of the pipeline sequencer (pipeline_ctrl).
package rv32i_types;

    // FETCH : fetch request on the bus, front end takes data as it arrives
    // HOLD  : one fetched word parked in the instruction buffer
    // SQUASH: redirect taken while a fetch was outstanding; the response is dropped
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard detector.
// Ports:
//   id_ex_memread       in   instruction in EX is a load
//   id_ex_rd            in   EX destination register
//   if_id_rs1/rs2       in   ID source registers
//   load_use            out  ID needs the load result one cycle too early
// rs2 is always compared, even for instructions that do not read it.
module hazard_detect
(
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rd,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    output logic       load_use
);

    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the five-stage rv32i pipeline.
// Drives load/flush of PC, IF/ID, ID/EX and load of EX/MEM, MEM/WB; owns the
// instruction fetch handshake with a one-word instruction buffer; resolves
// data-memory stalls, load-use hazards and EX redirects (including a redirect
// that lands while a fetch is outstanding).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_resp/imem_rdata     fetch response pulse and data
//   imem_read                fetch request, held until imem_resp
//   if_ir                    instruction presented to IF/ID
//   dmem_req/dmem_resp       MEM stage access pending / completed
//   id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2   hazard inputs
//   ex_redirect/ex_target    taken branch/jump from EX
//   pc_redirect/pc_target    PC mux select and redirect address
//   load_*/flush_*           stage register controls
//   perf_*                   performance counters
// Build option: define PIPE_CTRL_PERF_EN to build the three 32-bit wrapping
// performance counters; otherwise the perf_* outputs are tied to 0.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        imem_read,
    output logic [31:0] if_ir,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        flush_if_id,
    output logic        load_id_ex,
    output logic        flush_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_lu_stall,
    output logic [31:0] perf_flush
);

    pipe_ctrl_state_t state;
    logic [31:0]      ibuf;
    logic [31:0]      tgt;

    logic load_use;
    logic mem_stall;
    logic redirect_ok;
    logic advance;
    logic lu_stall;

    hazard_detect u_hazard (
        .id_ex_memread (id_ex_memread),
        .id_ex_rd      (id_ex_rd),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .load_use      (load_use)
    );

    // A redirect waits out a memory stall (EX is frozen so it persists);
    // in SQUASH EX holds a bubble, so any redirect there is spurious.
    assign mem_stall   = dmem_req && !dmem_resp;
    assign redirect_ok = ex_redirect && !mem_stall && (state != SQUASH);
    assign advance     = !mem_stall && !load_use;
    assign lu_stall    = load_use && !mem_stall && !redirect_ok;

    always_comb begin
        imem_read   = 1'b0;
        pc_redirect = 1'b0;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        flush_if_id = 1'b0;
        load_id_ex  = 1'b0;
        flush_id_ex = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        if_ir       = (state == HOLD)   ? ibuf : imem_rdata;
        pc_target   = (state == SQUASH) ? tgt  : ex_target;

        if (!rst) begin
            // Back end: frozen on mem_stall, bubble into EX on load-use or redirect
            load_ex_mem = !mem_stall;
            load_mem_wb = !mem_stall;
            load_id_ex  = !mem_stall && !lu_stall;
            flush_id_ex = lu_stall || redirect_ok;

            case (state)
                FETCH: begin
                    imem_read = 1'b1;
                    if (redirect_ok) begin
                        flush_if_id = 1'b1;
                        // With data in hand the PC can be redirected now;
                        // otherwise the redirect waits in SQUASH.
                        if (imem_resp) begin
                            load_pc     = 1'b1;
                            pc_redirect = 1'b1;
                        end
                    end else if (advance) begin
                        if (imem_resp) begin
                            load_if_id = 1'b1;
                            load_pc    = 1'b1;
                        end else begin
                            flush_if_id = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_ok) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        flush_if_id = 1'b1;
                    end else if (advance) begin
                        load_if_id = 1'b1;
                        load_pc    = 1'b1;
                    end
                end
                SQUASH: begin
                    imem_read = 1'b1;
                    // Completes even under mem_stall: only the front end moves.
                    if (imem_resp) begin
                        load_pc     = 1'b1;
                        pc_redirect = 1'b1;
                        flush_if_id = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ibuf  <= 32'd0;
            tgt   <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_ok && !imem_resp) begin
                        tgt   <= ex_target;
                        state <= SQUASH;
                    end else if (imem_resp && !redirect_ok && !advance) begin
                        ibuf  <= imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_ok || advance) begin
                        state <= FETCH;
                    end
                end
                SQUASH: begin
                    if (imem_resp) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cnt_mem_stall;
    logic [31:0] cnt_lu_stall;
    logic [31:0] cnt_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_mem_stall <= 32'd0;
            cnt_lu_stall  <= 32'd0;
            cnt_flush     <= 32'd0;
        end else begin
            if (mem_stall)              cnt_mem_stall <= cnt_mem_stall + 32'd1;
            if (load_use && !mem_stall) cnt_lu_stall  <= cnt_lu_stall + 32'd1;
            if (redirect_ok)            cnt_flush     <= cnt_flush + 32'd1;
        end
    end

    assign perf_mem_stall = cnt_mem_stall;
    assign perf_lu_stall  = cnt_lu_stall;
    assign perf_flush     = cnt_flush;
`else
    assign perf_mem_stall = 32'd0;
    assign perf_lu_stall  = 32'd0;
    assign perf_flush     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl. A stimulus process
// drives each cycle and pushes the expected outputs from a behavioural model
// (buffered-word / pending-redirect bookkeeping); a monitor pops and compares
// on the falling edge. Honours PIPE_CTRL_PERF_EN for the counter outputs.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_read;
    logic [31:0] if_ir;
    logic        dmem_req = 1'b0;
    logic        dmem_resp = 1'b0;
    logic        id_ex_memread = 1'b0;
    logic [4:0]  id_ex_rd = 5'd0;
    logic [4:0]  if_id_rs1 = 5'd0;
    logic [4:0]  if_id_rs2 = 5'd0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        load_pc, load_if_id, flush_if_id, load_id_ex, flush_id_ex;
    logic        load_ex_mem, load_mem_wb;
    logic [31:0] perf_mem_stall, perf_lu_stall, perf_flush;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .imem_read      (imem_read),
        .if_ir          (if_ir),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .id_ex_memread  (id_ex_memread),
        .id_ex_rd       (id_ex_rd),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target),
        .load_pc        (load_pc),
        .load_if_id     (load_if_id),
        .flush_if_id    (flush_if_id),
        .load_id_ex     (load_id_ex),
        .flush_id_ex    (flush_id_ex),
        .load_ex_mem    (load_ex_mem),
        .load_mem_wb    (load_mem_wb),
        .perf_mem_stall (perf_mem_stall),
        .perf_lu_stall  (perf_lu_stall),
        .perf_flush     (perf_flush)
    );

    always #5 clk = ~clk;

    // ctl = {imem_read, pc_redirect, load_pc, load_if_id, flush_if_id,
    //        load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}
    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] ir;
        logic [31:0] tg;
        logic [31:0] c0, c1, c2;
        bit          chk_data;
        bit          chk_cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model: a fetched word is either parked (m_has_buf) or a redirect is
    // waiting for the outstanding fetch to return (m_squash).
    bit          m_has_buf = 0;
    logic [31:0] m_buf = 32'd0;
    bit          m_squash = 0;
    logic [31:0] m_tgt = 32'd0;
    logic [31:0] m_c0 = 0, m_c1 = 0, m_c2 = 0;
    bit          m_known = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit stall, hz, take, lu, got;
        bit ird, pcr, lpc, lif, fif, lie, fie, lem, lmw;
        ird = 0; pcr = 0; lpc = 0; lif = 0; fif = 0; lie = 0; fie = 0; lem = 0; lmw = 0;
        stall = dmem_req && !dmem_resp;
        hz = id_ex_memread && id_ex_rd != 0 &&
             (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
`ifdef PIPE_CTRL_PERF_EN
        e.c0 = m_c0; e.c1 = m_c1; e.c2 = m_c2;
`else
        e.c0 = 0; e.c1 = 0; e.c2 = 0;
`endif
        e.chk_cnt  = m_known;
        e.chk_data = !rst;
        e.ir = m_has_buf ? m_buf : imem_rdata;
        e.tg = m_squash ? m_tgt : ex_target;
        if (rst) begin
            m_has_buf = 0; m_buf = 0; m_squash = 0; m_tgt = 0;
            m_c0 = 0; m_c1 = 0; m_c2 = 0; m_known = 1;
        end else begin
            take = ex_redirect && !stall && !m_squash;
            lu = hz && !stall && !take;
            if (!stall) begin lem = 1; lmw = 1; lie = !lu; end
            fie = lu || take;
            if (m_squash) begin
                ird = 1;
                if (imem_resp) begin lpc = 1; pcr = 1; fif = 1; m_squash = 0; end
            end else begin
                got = m_has_buf || imem_resp;
                ird = !m_has_buf;
                if (take) begin
                    fif = 1;
                    if (got) begin lpc = 1; pcr = 1; m_has_buf = 0; end
                    else begin m_squash = 1; m_tgt = ex_target; end
                end else if (!stall && !hz) begin
                    if (got) begin lif = 1; lpc = 1; m_has_buf = 0; end
                    else fif = 1;
                end else if (imem_resp && !m_has_buf) begin
                    m_has_buf = 1; m_buf = imem_rdata;
                end
            end
            if (stall) m_c0++;
            if (hz && !stall) m_c1++;
            if (take) m_c2++;
        end
        e.ctl = {ird, pcr, lpc, lif, fif, lie, fie, lem, lmw};
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit resp, input logic [31:0] rdata,
                       input bit dreq, input bit dresp, input bit mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit redir, input logic [31:0] tg);
        @(posedge clk);
        #1;
        rst = r; imem_resp = resp; imem_rdata = rdata;
        dmem_req = dreq; dmem_resp = dresp;
        id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
        ex_redirect = redir; ex_target = tg;
        model_step();
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctl", {23'd0, imem_read, pc_redirect, load_pc, load_if_id, flush_if_id,
                            load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}, {23'd0, e.ctl});
                if (e.chk_data) begin
                    chk("if_ir", if_ir, e.ir);
                    chk("pc_target", pc_target, e.tg);
                end
                if (e.chk_cnt) begin
                    chk("perf_mem_stall", perf_mem_stall, e.c0);
                    chk("perf_lu_stall", perf_lu_stall, e.c1);
                    chk("perf_flush", perf_flush, e.c2);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int wait_cyc;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // fetch stall 3 cycles, then response
        repeat (3) cyc(0, 0, 32'hdead_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs2
        cyc(0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0);
        cyc(0, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 0);
        // redirect while fetch outstanding
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99);
        cyc(0, 1, 32'h3333_3333, 0, 0, 0, 0, 0, 0, 0, 32'h99);
        // response during mem stall -> buffered
        cyc(0, 1, 32'h4444_4444, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 32'h5555_5555, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 32'h6666_6666, 1, 1, 0, 0, 0, 0, 0, 0);
        // simultaneous response and redirect
        cyc(0, 1, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 1, 32'h80);
        // reset, then 4 mem-stall cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // random
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2),
                ($urandom_range(99) < 40), $urandom,
                ($urandom_range(99) < 30), ($urandom_range(1) == 1),
                ($urandom_range(99) < 30), 5'($urandom_range(3)),
                5'($urandom_range(3)), 5'($urandom_range(3)),
                ($urandom_range(99) < 15), $urandom);
        end
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
